// File: rtl/csr_file_trap_if.sv
// CSR-file bus between the EX stage (master) and the machine-mode CSR file (slave).
// Carries the CSR access, trap/mret events, interrupt lines and the redirect/irq results.
interface csr_file_trap_if #(
    parameter int XLEN = 32
);
    logic [11:0]     csr_addr;
    logic [1:0]      csr_op;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;
    logic            trap_req;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] trap_val;
    logic            mret_req;
    logic            instret_inc;
    logic            irq_msip;
    logic            irq_mtip;
    logic            irq_meip;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            irq_pending;

    modport master (
        output csr_addr, csr_op, csr_wdata, trap_req, trap_cause, trap_pc, trap_val,
               mret_req, instret_inc, irq_msip, irq_mtip, irq_meip,
        input  csr_rdata, csr_illegal, redirect_valid, redirect_pc, irq_pending
    );

    modport slave (
        input  csr_addr, csr_op, csr_wdata, trap_req, trap_cause, trap_pc, trap_val,
               mret_req, instret_inc, irq_msip, irq_mtip, irq_meip,
        output csr_rdata, csr_illegal, redirect_valid, redirect_pc, irq_pending
    );
endinterface

// File: rtl/csr_file_trap.sv
// Machine-mode CSR file: CSRRW/RS/RC, trap entry, MRET, mcycle/minstret and interrupt pending.
// Reads and redirects are combinational; all state commits on the rising clock edge.
module csr_file_trap #(
    parameter int          XLEN      = 32,
    parameter int          CNT_WIDTH = 64,
    parameter logic [31:0] MTVEC_RST = 32'h0,
    parameter logic [31:0] HART_ID   = 32'h0,
    parameter bit          VECTORED  = 1'b1
) (
    input logic            clk,
    input logic            rst_n,
    csr_file_trap_if.slave bus
);
    localparam int HI_W = CNT_WIDTH - 32;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
    localparam logic [11:0] A_MIMPID    = 12'hF13;
    localparam logic [11:0] A_MHARTID   = 12'hF14;
    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;

    localparam logic [XLEN-1:0] MISA_VAL = 32'h4000_0100;
    localparam logic [XLEN-1:0] MIE_MASK = 32'h0000_0888;

    logic                 mst_mie_q, mst_mie_d;
    logic                 mst_mpie_q, mst_mpie_d;
    logic [XLEN-1:0]      mie_q, mie_d;
    logic [XLEN-1:0]      mtvec_q, mtvec_d;
    logic [XLEN-1:0]      mscratch_q, mscratch_d;
    logic [XLEN-1:0]      mepc_q, mepc_d;
    logic [XLEN-1:0]      mcause_q, mcause_d;
    logic [XLEN-1:0]      mtval_q, mtval_d;
    logic [2:0]           mip_q, mip_d;
    logic [CNT_WIDTH-1:0] mcycle_q, mcycle_d;
    logic [CNT_WIDTH-1:0] minstret_q, minstret_d;

    logic [63:0]     mcycle_ext, minstret_ext;
    logic [XLEN-1:0] mstatus_val, mip_val;
    logic [XLEN-1:0] rd_val, wr_val;
    logic [XLEN-1:0] mtvec_base, vec_off;
    logic            mapped, is_write, illegal, wr_en;

    // Counters zero-extend to 64 so the high halves read as 0 above CNT_WIDTH.
    assign mcycle_ext   = 64'(mcycle_q);
    assign minstret_ext = 64'(minstret_q);
    assign mstatus_val  = {19'b0, 2'b11, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
    assign mip_val      = {20'b0, mip_q[2], 3'b0, mip_q[1], 3'b0, mip_q[0], 3'b0};

    always_comb begin
        rd_val = '0;
        mapped = 1'b1;
        case (bus.csr_addr)
            A_MVENDORID, A_MARCHID, A_MIMPID: rd_val = '0;
            A_MHARTID:               rd_val = HART_ID;
            A_MSTATUS:               rd_val = mstatus_val;
            A_MISA:                  rd_val = MISA_VAL;
            A_MIE:                   rd_val = mie_q;
            A_MTVEC:                 rd_val = mtvec_q;
            A_MSCRATCH:              rd_val = mscratch_q;
            A_MEPC:                  rd_val = mepc_q;
            A_MCAUSE:                rd_val = mcause_q;
            A_MTVAL:                 rd_val = mtval_q;
            A_MIP:                   rd_val = mip_val;
            A_MCYCLE, A_CYCLE:       rd_val = mcycle_ext[31:0];
            A_MCYCLEH, A_CYCLEH:     rd_val = mcycle_ext[63:32];
            A_MINSTRET, A_INSTRET:   rd_val = minstret_ext[31:0];
            A_MINSTRETH, A_INSTRETH: rd_val = minstret_ext[63:32];
            default:                 mapped = 1'b0;
        endcase
    end

    always_comb begin
        case (bus.csr_op)
            OP_RS:   wr_val = rd_val | bus.csr_wdata;
            OP_RC:   wr_val = rd_val & ~bus.csr_wdata;
            default: wr_val = bus.csr_wdata;
        endcase
    end

    // RS/RC with a zero operand is a pure read, so it may target read-only space.
    assign is_write = (bus.csr_op == OP_RW) || (bus.csr_op != OP_NONE && bus.csr_wdata != '0);
    assign illegal  = (bus.csr_op != OP_NONE) &&
                      (!mapped || (is_write && bus.csr_addr[11:10] == 2'b11));
    assign wr_en    = is_write && !illegal && !bus.trap_req && !bus.mret_req;

    assign bus.csr_rdata   = illegal ? '0 : rd_val;
    assign bus.csr_illegal = rst_n & illegal;

    assign mtvec_base = {mtvec_q[XLEN-1:2], 2'b00};
    assign vec_off    = {bus.trap_cause[XLEN-3:0], 2'b00};

    always_comb begin
        bus.redirect_pc = mepc_q;
        if (bus.trap_req) begin
            bus.redirect_pc = mtvec_base;
            if (mtvec_q[0] && bus.trap_cause[XLEN-1])
                bus.redirect_pc = mtvec_base + vec_off;
        end
    end

    assign bus.redirect_valid = rst_n & (bus.trap_req | bus.mret_req);
    assign bus.irq_pending    = mst_mie_q & |(mip_q & {mie_q[11], mie_q[7], mie_q[3]});

    always_comb begin
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mip_d      = {bus.irq_meip, bus.irq_mtip, bus.irq_msip};
        mcycle_d   = mcycle_q + CNT_WIDTH'(1);
        minstret_d = minstret_q + CNT_WIDTH'(bus.instret_inc);

        if (bus.trap_req) begin
            mepc_d     = {bus.trap_pc[XLEN-1:2], 2'b00};
            mcause_d   = bus.trap_cause;
            mtval_d    = bus.trap_val;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
        end else if (bus.mret_req) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
        end else if (wr_en) begin
            // A half-write replaces that half and suppresses the increment this cycle.
            case (bus.csr_addr)
                A_MSTATUS: begin
                    mst_mie_d  = wr_val[3];
                    mst_mpie_d = wr_val[7];
                end
                A_MIE:       mie_d      = wr_val & MIE_MASK;
                A_MTVEC:     mtvec_d    = {wr_val[XLEN-1:2], 1'b0, VECTORED & wr_val[0]};
                A_MSCRATCH:  mscratch_d = wr_val;
                A_MEPC:      mepc_d     = {wr_val[XLEN-1:2], 2'b00};
                A_MCAUSE:    mcause_d   = wr_val;
                A_MTVAL:     mtval_d    = wr_val;
                A_MCYCLE:    mcycle_d   = {mcycle_q[CNT_WIDTH-1:32], wr_val};
                A_MCYCLEH:   mcycle_d   = {wr_val[HI_W-1:0], mcycle_q[31:0]};
                A_MINSTRET:  minstret_d = {minstret_q[CNT_WIDTH-1:32], wr_val};
                A_MINSTRETH: minstret_d = {wr_val[HI_W-1:0], minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mip_q      <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mip_q      <= mip_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
endmodule

// File: tb/tb_csr_file_trap.sv
// Directed + random bench for csr_file_trap against a behavioural CSR model.
module tb_csr_file_trap;
    localparam int          CW    = 40;
    localparam logic [31:0] HID   = 32'h0000_0005;
    localparam logic [31:0] MTV0  = 32'h0000_0040;
    localparam longint unsigned CMASK = (64'd1 << CW) - 64'd1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    csr_file_trap_if #(.XLEN(32)) bus ();

    csr_file_trap #(
        .XLEN(32), .CNT_WIDTH(CW), .MTVEC_RST(MTV0), .HART_ID(HID), .VECTORED(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit              m_mie, m_mpie;
    logic [31:0]     m_mie_r, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    bit   [2:0]      m_mip;
    longint unsigned m_cyc, m_ins;

    logic [11:0] addrs [24] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                12'h342, 12'h343, 12'h344, 12'hF11, 12'hF12, 12'hF13,
                                12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
                                12'hC80, 12'hC02, 12'hC82, 12'h7C0, 12'h123, 12'h306};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_mie = 0; m_mpie = 0; m_mie_r = '0; m_mtvec = MTV0; m_mscratch = '0;
        m_mepc = '0; m_mcause = '0; m_mtval = '0; m_mip = '0; m_cyc = 0; m_ins = 0;
    endfunction

    function automatic void m_read(input logic [11:0] a, output bit ok, output logic [31:0] v);
        ok = 1;
        v  = '0;
        case (a)
            12'hF11, 12'hF12, 12'hF13: v = '0;
            12'hF14: v = HID;
            12'h300: v = 32'h1800 | (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
            12'h301: v = 32'h4000_0100;
            12'h304: v = m_mie_r;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'h344: v = (m_mip[0] ? 32'h8 : 0) | (m_mip[1] ? 32'h80 : 0) | (m_mip[2] ? 32'h800 : 0);
            12'hB00, 12'hC00: v = m_cyc[31:0];
            12'hB80, 12'hC80: v = m_cyc[63:32];
            12'hB02, 12'hC02: v = m_ins[31:0];
            12'hB82, 12'hC82: v = m_ins[63:32];
            default: ok = 0;
        endcase
    endfunction

    task automatic drive(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
        bus.csr_addr = a; bus.csr_op = op; bus.csr_wdata = wd;
    endtask

    task automatic ev(input bit t, input bit m, input logic [31:0] cause, input logic [31:0] pc);
        bus.trap_req = t; bus.mret_req = m; bus.trap_cause = cause; bus.trap_pc = pc;
        bus.trap_val = pc ^ 32'h5A5A_0000;
    endtask

    // Called just after a falling edge; checks outputs, then advances the model one cycle.
    task automatic tick();
        bit ok, wr, ill, cwr, iwr;
        logic [31:0] v, wv, base, exp_pc;
        logic [11:0] a;
        #1;
        a = bus.csr_addr;
        m_read(a, ok, v);
        wr  = (bus.csr_op == 2'b01) || (bus.csr_op != 2'b00 && bus.csr_wdata != 0);
        ill = (bus.csr_op != 2'b00) && (!ok || (wr && a[11:10] == 2'b11));
        chk("illegal", {31'b0, bus.csr_illegal}, {31'b0, ill});
        chk("rdata", bus.csr_rdata, ill ? 32'h0 : v);
        chk("redir_valid", {31'b0, bus.redirect_valid}, {31'b0, bus.trap_req | bus.mret_req});
        base = m_mtvec & ~32'h3;
        if (bus.trap_req)
            exp_pc = base + ((m_mtvec[0] && bus.trap_cause[31]) ? (bus.trap_cause << 2) : 32'h0);
        else
            exp_pc = m_mepc;
        if (bus.trap_req || bus.mret_req) chk("redir_pc", bus.redirect_pc, exp_pc);
        chk("irq_pending", {31'b0, bus.irq_pending},
            {31'b0, m_mie && ((m_mip[0] && m_mie_r[3]) || (m_mip[1] && m_mie_r[7]) || (m_mip[2] && m_mie_r[11]))});
        @(posedge clk);
        case (bus.csr_op)
            2'b10:   wv = v | bus.csr_wdata;
            2'b11:   wv = v & ~bus.csr_wdata;
            default: wv = bus.csr_wdata;
        endcase
        cwr = 0; iwr = 0;
        if (bus.trap_req) begin
            m_mepc = bus.trap_pc & ~32'h3; m_mcause = bus.trap_cause; m_mtval = bus.trap_val;
            m_mpie = m_mie; m_mie = 0;
        end else if (bus.mret_req) begin
            m_mie = m_mpie; m_mpie = 1;
        end else if (wr && !ill) begin
            case (a)
                12'h300: begin m_mie = wv[3]; m_mpie = wv[7]; end
                12'h304: m_mie_r = wv & 32'h888;
                12'h305: m_mtvec = wv & ~32'h2;
                12'h340: m_mscratch = wv;
                12'h341: m_mepc = wv & ~32'h3;
                12'h342: m_mcause = wv;
                12'h343: m_mtval = wv;
                12'hB00: begin m_cyc = (m_cyc & ~64'hFFFF_FFFF) | 64'(wv); cwr = 1; end
                12'hB80: begin m_cyc = ((64'(wv) << 32) | (m_cyc & 64'hFFFF_FFFF)) & CMASK; cwr = 1; end
                12'hB02: begin m_ins = (m_ins & ~64'hFFFF_FFFF) | 64'(wv); iwr = 1; end
                12'hB82: begin m_ins = ((64'(wv) << 32) | (m_ins & 64'hFFFF_FFFF)) & CMASK; iwr = 1; end
                default: ;
            endcase
        end
        if (!cwr) m_cyc = (m_cyc + 1) & CMASK;
        if (!iwr && bus.instret_inc) m_ins = (m_ins + 1) & CMASK;
        m_mip = {bus.irq_meip, bus.irq_mtip, bus.irq_msip};
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_irq", {31'b0, bus.irq_pending}, 32'h0);
        chk("rst_redir", {31'b0, bus.redirect_valid}, 32'h0);
        chk("rst_illegal", {31'b0, bus.csr_illegal}, 32'h0);
        m_reset();
        drive(12'h0, 2'b00, 32'h0);
        ev(0, 0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        drive(12'h0, 2'b00, 32'h0);
        ev(0, 0, 32'h0, 32'h0);
        bus.instret_inc = 0; bus.irq_msip = 0; bus.irq_mtip = 0; bus.irq_meip = 0;
        #2;
        do_reset();

        // Reset state
        drive(12'h300, 2'b00, 0); #1 chk("rst_mstatus", bus.csr_rdata, 32'h1800); tick();
        drive(12'h305, 2'b00, 0); #1 chk("rst_mtvec", bus.csr_rdata, MTV0); tick();
        drive(12'hF14, 2'b00, 0); #1 chk("mhartid", bus.csr_rdata, HID); tick();
        drive(12'h301, 2'b00, 0); #1 chk("misa", bus.csr_rdata, 32'h4000_0100); tick();

        // mstatus WARL and mie set/clear
        drive(12'h300, 2'b01, 32'hFFFF_FFFF); tick();
        drive(12'h300, 2'b00, 0); #1 chk("mstatus_warl", bus.csr_rdata, 32'h1888); tick();
        drive(12'h304, 2'b10, 32'h8); #1 chk("mie_rs_old", bus.csr_rdata, 32'h0); tick();
        drive(12'h304, 2'b11, 32'h8); #1 chk("mie_rc_old", bus.csr_rdata, 32'h8); tick();
        drive(12'h304, 2'b00, 0); #1 chk("mie_final", bus.csr_rdata, 32'h0); tick();

        // Illegal accesses
        drive(12'hF14, 2'b01, 32'h123); #1 chk("ill_f14", {31'b0, bus.csr_illegal}, 32'h1); tick();
        drive(12'h7C0, 2'b01, 32'h123); #1 chk("ill_7c0", {31'b0, bus.csr_illegal}, 32'h1); tick();
        drive(12'hF14, 2'b10, 32'h0); #1 chk("rs0_ro_legal", {31'b0, bus.csr_illegal}, 32'h0); tick();
        drive(12'hF14, 2'b00, 0); #1 chk("hartid_kept", bus.csr_rdata, HID); tick();

        // Vectored trap entry
        drive(12'h305, 2'b01, 32'h101); tick();
        drive(12'h300, 2'b01, 32'h8); tick();
        drive(12'h000, 2'b00, 0); ev(1, 0, 32'h8000_0007, 32'h2002);
        #1 chk("trap_pc", bus.redirect_pc, 32'h11C); tick();
        ev(0, 0, 0, 0);
        drive(12'h341, 2'b00, 0); #1 chk("mepc", bus.csr_rdata, 32'h2000); tick();
        drive(12'h300, 2'b00, 0); #1 chk("trap_mstatus", bus.csr_rdata, 32'h1880); tick();

        // Trap beats mret beats CSR write
        drive(12'h340, 2'b01, 32'hAAAA); tick();
        drive(12'h300, 2'b10, 32'h8); tick();
        drive(12'h340, 2'b01, 32'h5555); ev(1, 1, 32'h2, 32'h3000);
        #1 chk("prio_pc", bus.redirect_pc, 32'h100); tick();
        ev(0, 0, 0, 0);
        drive(12'h340, 2'b00, 0); #1 chk("mscratch_kept", bus.csr_rdata, 32'hAAAA); tick();
        drive(12'h000, 2'b00, 0); ev(0, 1, 0, 0);
        #1 chk("mret_pc", bus.redirect_pc, 32'h3000); tick();
        ev(0, 0, 0, 0);
        drive(12'h300, 2'b00, 0); #1 chk("mret_mstatus", bus.csr_rdata, 32'h1888); tick();

        // Counter carry and wrap at CNT_WIDTH
        drive(12'hB00, 2'b01, 32'hFFFF_FFFF); tick();
        drive(12'hB00, 2'b00, 0); #1 chk("cyc_lo_max", bus.csr_rdata, 32'hFFFF_FFFF); tick();
        drive(12'hB80, 2'b00, 0); #1 chk("cyc_carry_hi", bus.csr_rdata, 32'h1); tick();
        drive(12'hB00, 2'b00, 0); #1 chk("cyc_carry_lo", bus.csr_rdata, 32'h1); tick();
        drive(12'hB80, 2'b01, 32'hFFFF_FFFF); tick();
        drive(12'hB00, 2'b01, 32'hFFFF_FFFF); tick();
        drive(12'hB80, 2'b00, 0); #1 chk("cyc_hi_trunc", bus.csr_rdata, 32'hFF); tick();
        drive(12'hB80, 2'b00, 0); #1 chk("cyc_wrap_hi", bus.csr_rdata, 32'h0); tick();
        drive(12'hC00, 2'b00, 0); #1 chk("cyc_wrap_lo", bus.csr_rdata, 32'h1); tick();

        // Interrupt pending latency, then async reset mid-pulse
        drive(12'h304, 2'b01, 32'h80); tick();
        drive(12'h300, 2'b01, 32'h8); tick();
        bus.irq_mtip = 1;
        drive(12'h344, 2'b00, 0); #1 chk("irq_same_cycle", {31'b0, bus.irq_pending}, 32'h0); tick();
        drive(12'h344, 2'b00, 0); #1 chk("irq_next_cycle", {31'b0, bus.irq_pending}, 32'h1); tick();
        drive(12'h7C0, 2'b01, 32'h1); ev(1, 0, 32'h5, 32'h40);
        do_reset();
        drive(12'h304, 2'b00, 0); #1 chk("post_rst_mie", bus.csr_rdata, 32'h0); tick();
        bus.irq_mtip = 0;

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [31:0] wd;
            wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            drive(addrs[$urandom_range(0, 23)], 2'($urandom_range(0, 3)), wd);
            ev($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
               {1'($urandom_range(0, 1)), 27'b0, 4'($urandom_range(0, 15))}, $urandom);
            bus.instret_inc = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) bus.irq_msip = ~bus.irq_msip;
            if ($urandom_range(0, 7) == 0) bus.irq_mtip = ~bus.irq_mtip;
            if ($urandom_range(0, 7) == 0) bus.irq_meip = ~bus.irq_meip;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
